// File: rtl/pe_pkg.sv
// Shared types and helpers for the PE column partial-sum path.
// Optional build macro PSUM_SAT_EN (consumed by pe_psum_drain) selects saturating accumulation.
package pe_pkg;

   localparam int SUM_W_DEF = 24;
   localparam int ACC_W_DEF = 32;
   localparam int CNT_W_DEF = 8;
   localparam int DEPTH_DEF = 4;

   typedef logic signed [SUM_W_DEF-1:0] psum_t;
   typedef logic signed [ACC_W_DEF-1:0] acc_t;

   typedef enum logic {
      DRAIN_IDLE  = 1'b0,
      DRAIN_ACCUM = 1'b1
   } drain_state_e;

   typedef struct packed {
      logic               ovf;
      logic signed [63:0] sum;
   } add_res_t;

   // Operands arrive sign-extended to 64 bits; w (< 64) is the target signed width.
   // The 64-bit sum is exact, so range checks against the w-bit limits detect overflow.
   function automatic add_res_t sat_add(input logic signed [63:0] a,
                                        input logic signed [63:0] b,
                                        input int                 w,
                                        input logic               sat);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      logic signed [63:0] s;
      add_res_t           r;
      hi    = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo    = -hi - 64'sd1;
      s     = a + b;
      r.ovf = (s > hi) || (s < lo);
      r.sum = s;
      if (sat && (s > hi)) r.sum = hi;
      else if (sat && (s < lo)) r.sum = lo;
      return r;
   endfunction

endpackage

// File: rtl/pe_result_fifo.sv
// Small synchronous FIFO holding finished group results; full/empty are registered flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module pe_result_fifo #(
   parameter int W     = 40,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          full_q;
   logic          empty_q;
   logic          do_push;
   logic          do_pop;

   assign do_push  = push && !full_q;
   assign do_pop   = pop && !empty_q;
   assign pop_data = mem[rd_ptr];
   assign full     = full_q;
   assign empty    = empty_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         full_q  <= 1'b0;
         empty_q <= 1'b1;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         // Simultaneous push and pop leaves occupancy and flags untouched.
         case ({do_push, do_pop})
            2'b10: begin
               count   <= count + (AW+1)'(1);
               full_q  <= (count == (AW+1)'(DEPTH - 1));
               empty_q <= 1'b0;
            end
            2'b01: begin
               count   <= count - (AW+1)'(1);
               empty_q <= (count == (AW+1)'(1));
               full_q  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/pe_psum_drain.sv
// Column-bottom sink: folds PE partial-sum beats into per-group results and queues them.
// Build macro PSUM_SAT_EN: saturate the accumulator on overflow instead of wrapping.
module pe_psum_drain
   import pe_pkg::*;
#(
   parameter int SUM_W = SUM_W_DEF,
   parameter int ACC_W = ACC_W_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             i_valid,
   output logic             i_ready,
   input  logic [SUM_W-1:0] i_sum,
   input  logic             i_last,
   output logic             o_valid,
   input  logic             o_ready,
   output logic [ACC_W-1:0] o_data,
   output logic [CNT_W-1:0] o_beats,
   output logic             o_ovf,
   output drain_state_e     dbg_state
);

`ifdef PSUM_SAT_EN
   localparam logic SAT_EN = 1'b1;
`else
   localparam logic SAT_EN = 1'b0;
`endif

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   drain_state_e       state;
   logic [ACC_W-1:0]   acc_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               ovf_q;
   logic               run_q;
   logic               fifo_full;
   logic               fifo_empty;
   logic               beat;
   logic               push;
   logic               pop;
   logic [ACC_W-1:0]   sext_sum;
   logic [ACC_W-1:0]   acc_next;
   logic [CNT_W-1:0]   cnt_inc;
   add_res_t           add_r;
   logic [ACC_W+CNT_W-1:0] push_data;
   logic [ACC_W+CNT_W-1:0] head;
   logic               unused_hi;

   // Both ports: a transfer happens on a clock edge where valid && ready; valid never waits on ready.
   assign beat     = i_valid && i_ready;
   assign i_ready  = run_q && !fifo_full;
   assign pop      = o_valid && o_ready;
   assign o_valid  = !fifo_empty;
   assign o_data   = head[ACC_W+CNT_W-1:CNT_W];
   assign o_beats  = head[CNT_W-1:0];
   assign o_ovf    = ovf_q;
   assign dbg_state = state;

   assign sext_sum  = ACC_W'(signed'(i_sum));
   assign add_r     = sat_add(64'(signed'(acc_q)), 64'(signed'(i_sum)), ACC_W, SAT_EN);
   assign acc_next  = add_r.sum[ACC_W-1:0];
   assign unused_hi = ^add_r.sum[63:ACC_W];
   assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);

   assign push      = beat && i_last;
   assign push_data = (state == DRAIN_ACCUM) ? {acc_next, cnt_inc} : {sext_sum, CNT_W'(1)};

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= DRAIN_IDLE;
         acc_q <= '0;
         cnt_q <= '0;
         ovf_q <= 1'b0;
         run_q <= 1'b0;
      end else begin
         run_q <= 1'b1;
         if (beat) begin
            case (state)
               DRAIN_IDLE: begin
                  // A last beat here is a single-beat group and goes straight to the FIFO.
                  if (!i_last) begin
                     acc_q <= sext_sum;
                     cnt_q <= CNT_W'(1);
                     state <= DRAIN_ACCUM;
                  end
               end
               DRAIN_ACCUM: begin
                  if (add_r.ovf) ovf_q <= 1'b1;
                  if (!i_last) begin
                     acc_q <= acc_next;
                     cnt_q <= cnt_inc;
                  end else begin
                     acc_q <= '0;
                     cnt_q <= '0;
                     state <= DRAIN_IDLE;
                  end
               end
               default: state <= DRAIN_IDLE;
            endcase
         end
      end
   end

   pe_result_fifo #(
      .W     (ACC_W + CNT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset_n   (reset_n),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

endmodule
